// File: rtl/lsu.sv
// Load/store unit: accepts one op at a time from execute, drives a single-port
// DCCM (word reads, full-word writes) and produces register-file writeback.
// Sub-word stores use a read-modify-write through the same DCCM port.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [10:0] opcode_exe_2_mem_i,
    input  logic [4:0]  rd_exe_2_mem_i,
    input  logic [31:0] rd_data_exe_2_mem_i,
    input  logic [31:0] mem_address_i,
    input  logic [31:0] mem_data_i,
    input  logic        flush_i,
    output logic        dccm_rd_en,
    output logic [31:0] dccm_rd_addr,
    output logic        dccm_wr_en,
    output logic [31:0] dccm_wr_addr,
    output logic [31:0] dccm_wr_data,
    input  logic [31:0] dccm_rd_data,
    output logic        wb_en_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        mem_err_o
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef enum logic [1:0] {StIdle, StRd, StLdCap, StRmwCap} state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [4:0]  rd_q, rd_d;
    logic [15:0] st_data_q, st_data_d;

    logic        rd_en_q, rd_en_d, wr_en_q, wr_en_d, wb_en_q, wb_en_d, err_q, err_d;
    logic [31:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;

    // Bit 10 of the op format only distinguishes ALU variants, irrelevant here.
    logic unused_op_bit;
    assign unused_op_bit = opcode_exe_2_mem_i[10];

    // Input decode, only meaningful in the accept cycle.
    logic [2:0]  in_f3;
    logic        in_load, in_store, in_bad_f3, in_misal;
    logic [31:0] in_word_addr;
    assign in_f3        = opcode_exe_2_mem_i[9:7];
    assign in_load      = opcode_exe_2_mem_i[6:0] == OpLoad;
    assign in_store     = opcode_exe_2_mem_i[6:0] == OpStore;
    // Loads support 0,1,2,4,5; stores 0,1,2.
    assign in_bad_f3    = in_store ? (in_f3 > 3'd2) : (in_f3 == 3'd3 || in_f3[2:1] == 2'b11);
    assign in_misal     = (in_f3[1:0] == 2'b10 && mem_address_i[1:0] != 2'b00) ||
                          (in_f3[1:0] == 2'b01 && mem_address_i[0]);
    assign in_word_addr = {mem_address_i[31:2], 2'b00};

    // Load lane extraction with sign/zero extension.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    always_comb begin
        ld_byte = dccm_rd_data[8*addr_lo_q +: 8];
        ld_half = addr_lo_q[1] ? dccm_rd_data[31:16] : dccm_rd_data[15:0];
        unique case (funct3_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_ext = {24'h0, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_ext = {16'h0, ld_half};
            default: ld_ext = dccm_rd_data;
        endcase
    end

    // Merge store byte/half into the word read back from DCCM.
    logic [31:0] merged;
    always_comb begin
        merged = dccm_rd_data;
        if (funct3_q[0]) begin
            if (addr_lo_q[1]) merged[31:16] = st_data_q;
            else              merged[15:0]  = st_data_q;
        end else begin
            merged[8*addr_lo_q +: 8] = st_data_q[7:0];
        end
    end

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        is_store_d = is_store_q;
        addr_lo_d  = addr_lo_q;
        rd_d       = rd_q;
        st_data_d  = st_data_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        wb_en_d    = 1'b0;
        err_d      = 1'b0;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i && !flush_i) begin
                    if (in_load || in_store) begin
                        if (in_bad_f3 || in_misal) begin
                            err_d = 1'b1;
                        end else if (in_store && in_f3 == 3'd2) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = in_word_addr;
                            wr_data_d = mem_data_i;
                        end else begin
                            rd_en_d    = 1'b1;
                            rd_addr_d  = in_word_addr;
                            funct3_d   = in_f3;
                            is_store_d = in_store;
                            addr_lo_d  = mem_address_i[1:0];
                            rd_d       = rd_exe_2_mem_i;
                            st_data_d  = mem_data_i[15:0];
                            state_d    = StRd;
                        end
                    end else begin
                        wb_en_d   = rd_exe_2_mem_i != 5'd0;
                        wb_rd_d   = rd_exe_2_mem_i;
                        wb_data_d = rd_data_exe_2_mem_i;
                    end
                end
            end
            StRd: begin
                if (flush_i)         state_d = StIdle;
                else if (is_store_q) state_d = StRmwCap;
                else                 state_d = StLdCap;
            end
            StLdCap: begin
                state_d = StIdle;
                if (!flush_i) begin
                    wb_en_d   = rd_q != 5'd0;
                    wb_rd_d   = rd_q;
                    wb_data_d = ld_ext;
                end
            end
            StRmwCap: begin
                state_d = StIdle;
                if (!flush_i) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = rd_addr_q;
                    wr_data_d = merged;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            funct3_q   <= 3'd0;
            is_store_q <= 1'b0;
            addr_lo_q  <= 2'd0;
            rd_q       <= 5'd0;
            st_data_q  <= 16'h0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wb_en_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_addr_q  <= 32'h0;
            wr_addr_q  <= 32'h0;
            wr_data_q  <= 32'h0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            is_store_q <= is_store_d;
            addr_lo_q  <= addr_lo_d;
            rd_q       <= rd_d;
            st_data_q  <= st_data_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            wb_en_q    <= wb_en_d;
            err_q      <= err_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign ready_o      = state_q == StIdle;
    assign dccm_rd_en   = rd_en_q;
    assign dccm_rd_addr = rd_addr_q;
    assign dccm_wr_en   = wr_en_q;
    assign dccm_wr_addr = wr_addr_q;
    assign dccm_wr_data = wr_data_q;
    assign wb_en_o      = wb_en_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign mem_err_o    = err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single-cycle ops plus hand-written
// sequences for loads, read-modify-write stores, flush and mid-op reset.
module tb_lsu;

    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSt  = 7'b0100011;
    localparam logic [6:0] OpAlu = 7'b0110011;
    localparam logic [6:0] OpLui = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, flush_i;
    logic [10:0] opcode_exe_2_mem_i;
    logic [4:0]  rd_exe_2_mem_i;
    logic [31:0] rd_data_exe_2_mem_i, mem_address_i, mem_data_i;
    logic        dccm_rd_en, dccm_wr_en;
    logic [31:0] dccm_rd_addr, dccm_wr_addr, dccm_wr_data, dccm_rd_data;
    logic        wb_en_o, mem_err_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_word = 32'h0;

    always #5 clk = ~clk;

    lsu dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .valid_i             (valid_i),
        .ready_o             (ready_o),
        .opcode_exe_2_mem_i  (opcode_exe_2_mem_i),
        .rd_exe_2_mem_i      (rd_exe_2_mem_i),
        .rd_data_exe_2_mem_i (rd_data_exe_2_mem_i),
        .mem_address_i       (mem_address_i),
        .mem_data_i          (mem_data_i),
        .flush_i             (flush_i),
        .dccm_rd_en          (dccm_rd_en),
        .dccm_rd_addr        (dccm_rd_addr),
        .dccm_wr_en          (dccm_wr_en),
        .dccm_wr_addr        (dccm_wr_addr),
        .dccm_wr_data        (dccm_wr_data),
        .dccm_rd_data        (dccm_rd_data),
        .wb_en_o             (wb_en_o),
        .wb_rd_o             (wb_rd_o),
        .wb_data_o           (wb_data_o),
        .mem_err_o           (mem_err_o)
    );

    // DCCM model: data valid the cycle after a read; junk otherwise.
    always @(posedge clk) dccm_rd_data <= dccm_rd_en ? mem_word : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] opc(input logic [2:0] f3, input logic [6:0] op);
        return {1'b0, f3, op};
    endfunction

    // Present an op now (at a negedge) and advance past its accept edge.
    task automatic issue(input logic [10:0] op, input logic [4:0] rd, input logic [31:0] rdat,
                         input logic [31:0] addr, input logic [31:0] wdat);
        valid_i             = 1'b1;
        opcode_exe_2_mem_i  = op;
        rd_exe_2_mem_i      = rd;
        rd_data_exe_2_mem_i = rdat;
        mem_address_i       = addr;
        mem_data_i          = wdat;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "/pulses"}, {28'h0, wb_en_o, dccm_wr_en, mem_err_o, dccm_rd_en}, 32'h0);
    endtask

    // Multi-cycle load or RMW store; inputs are scrambled during the stall.
    task automatic run_mem(input string name, input logic [10:0] op, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [31:0] word, input bit is_st, input logic [31:0] exp);
        mem_word = word;
        issue(op, rd, 32'h0, addr, wdat);
        valid_i = 1'b1;
        opcode_exe_2_mem_i  = opc(3'd0, OpAlu);
        rd_exe_2_mem_i      = 5'd7;
        rd_data_exe_2_mem_i = 32'h6666_6666;
        mem_address_i       = 32'hFFFF_FFFF;
        chk({name, "/T1 rd_en"}, {31'h0, dccm_rd_en}, 32'd1);
        chk({name, "/T1 rd_addr"}, dccm_rd_addr, {addr[31:2], 2'b00});
        chk({name, "/T1 ready"}, {31'h0, ready_o}, 32'd0);
        @(negedge clk);
        chk({name, "/T2 ready"}, {31'h0, ready_o}, 32'd0);
        chk_quiet({name, "/T2"});
        @(negedge clk);
        valid_i = 1'b0;
        chk({name, "/T3 ready"}, {31'h0, ready_o}, 32'd1);
        if (is_st) begin
            chk({name, "/T3 wr_en"}, {31'h0, dccm_wr_en}, 32'd1);
            chk({name, "/T3 wr_addr"}, dccm_wr_addr, {addr[31:2], 2'b00});
            chk({name, "/T3 wr_data"}, dccm_wr_data, exp);
            chk({name, "/T3 wb_en"}, {31'h0, wb_en_o}, 32'd0);
        end else begin
            chk({name, "/T3 wb_en"}, {31'h0, wb_en_o}, {31'h0, rd != 5'd0});
            if (rd != 5'd0) begin
                chk({name, "/T3 wb_rd"}, {27'h0, wb_rd_o}, {27'h0, rd});
                chk({name, "/T3 wb_data"}, wb_data_o, exp);
            end
            chk({name, "/T3 wr_en"}, {31'h0, dccm_wr_en}, 32'd0);
        end
        @(negedge clk);
        chk_quiet({name, "/T4"});
    endtask

    typedef struct {
        logic [10:0] op;
        logic [4:0]  rd;
        logic [31:0] rdat;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic        wb_en;
        logic [31:0] wb_data;
        logic        wr_en;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{opc(3'd0, OpAlu), 5'd5,  32'h0000_1234, 32'h0, 32'h0,
                     1'b1, 32'h0000_1234, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1]  = '{opc(3'd0, OpAlu), 5'd0,  32'h0000_0055, 32'h0, 32'h0,
                     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[2]  = '{opc(3'd0, OpLui), 5'd31, 32'hABCD_E000, 32'h0, 32'h0,
                     1'b1, 32'hABCD_E000, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[3]  = '{opc(3'd2, OpSt),  5'd0,  32'h0, 32'h0000_0204, 32'hCAFE_F00D,
                     1'b0, 32'h0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 1'b0};
        vecs[4]  = '{opc(3'd2, OpSt),  5'd0,  32'h0, 32'h0000_0306, 32'h1111_1111,
                     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[5]  = '{opc(3'd2, OpLd),  5'd3,  32'h0, 32'h0000_0101, 32'h0,
                     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[6]  = '{opc(3'd1, OpLd),  5'd3,  32'h0, 32'h0000_0103, 32'h0,
                     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[7]  = '{opc(3'd3, OpLd),  5'd3,  32'h0, 32'h0000_0000, 32'h0,
                     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[8]  = '{opc(3'd3, OpSt),  5'd0,  32'h0, 32'h0000_0000, 32'h0,
                     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[9]  = '{opc(3'd1, OpSt),  5'd0,  32'h0, 32'h0000_0201, 32'h0,
                     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{opc(3'd5, OpLd),  5'd3,  32'h0, 32'h0000_0105, 32'h0,
                     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};

        rst_n = 1'b0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        opcode_exe_2_mem_i  = '0;
        rd_exe_2_mem_i      = '0;
        rd_data_exe_2_mem_i = '0;
        mem_address_i       = '0;
        mem_data_i          = '0;
        #1;
        chk("reset/pulses", {28'h0, wb_en_o, dccm_wr_en, mem_err_o, dccm_rd_en}, 32'h0);
        chk("reset/rd_addr", dccm_rd_addr, 32'h0);
        chk("reset/wb_data", wb_data_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset/ready", {31'h0, ready_o}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].rdat, vecs[i].addr, vecs[i].wdat);
            chk($sformatf("vec%0d/wb_en", i), {31'h0, wb_en_o}, {31'h0, vecs[i].wb_en});
            if (vecs[i].wb_en) begin
                chk($sformatf("vec%0d/wb_rd", i), {27'h0, wb_rd_o}, {27'h0, vecs[i].rd});
                chk($sformatf("vec%0d/wb_data", i), wb_data_o, vecs[i].wb_data);
            end
            chk($sformatf("vec%0d/wr_en", i), {31'h0, dccm_wr_en}, {31'h0, vecs[i].wr_en});
            if (vecs[i].wr_en) begin
                chk($sformatf("vec%0d/wr_addr", i), dccm_wr_addr, vecs[i].wr_addr);
                chk($sformatf("vec%0d/wr_data", i), dccm_wr_data, vecs[i].wr_data);
            end
            chk($sformatf("vec%0d/err", i), {31'h0, mem_err_o}, {31'h0, vecs[i].err});
            chk($sformatf("vec%0d/rd_en", i), {31'h0, dccm_rd_en}, 32'd0);
            chk($sformatf("vec%0d/ready", i), {31'h0, ready_o}, 32'd1);
            @(negedge clk);
            chk_quiet($sformatf("vec%0d/next", i));
        end

        run_mem("LB",   opc(3'd0, OpLd), 5'd8,  32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b0,
                32'hFFFF_FF80);
        run_mem("LBU",  opc(3'd4, OpLd), 5'd8,  32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b0,
                32'h0000_0080);
        run_mem("LH",   opc(3'd1, OpLd), 5'd9,  32'h0000_0102, 32'h0, 32'h80FF_0000, 1'b0,
                32'hFFFF_80FF);
        run_mem("LHU",  opc(3'd5, OpLd), 5'd10, 32'h0000_0100, 32'h0, 32'h1234_8765, 1'b0,
                32'h0000_8765);
        run_mem("LW",   opc(3'd2, OpLd), 5'd11, 32'h0000_0108, 32'h0, 32'h0BAD_F00D, 1'b0,
                32'h0BAD_F00D);
        run_mem("LB1",  opc(3'd0, OpLd), 5'd12, 32'h0000_0101, 32'h0, 32'h1122_3344, 1'b0,
                32'h0000_0033);
        run_mem("LBr0", opc(3'd0, OpLd), 5'd0,  32'h0000_0101, 32'h0, 32'h1122_3344, 1'b0,
                32'h0);
        run_mem("SH",   opc(3'd1, OpSt), 5'd0,  32'h0000_0202, 32'hAAAA_BEEF, 32'h1122_3344,
                1'b1, 32'hBEEF_3344);
        run_mem("SB1",  opc(3'd0, OpSt), 5'd0,  32'h0000_0301, 32'h1234_5677, 32'hAABB_CCDD,
                1'b1, 32'hAABB_77DD);
        run_mem("SB3",  opc(3'd0, OpSt), 5'd0,  32'h0000_0303, 32'h0000_005A, 32'h0000_0000,
                1'b1, 32'h5A00_0000);
        run_mem("SH0",  opc(3'd1, OpSt), 5'd0,  32'h0000_0400, 32'h0000_1357, 32'hFFFF_FFFF,
                1'b1, 32'hFFFF_1357);

        // Flush during load capture: no writeback, then a store proceeds.
        mem_word = 32'h5555_5555;
        issue(opc(3'd2, OpLd), 5'd9, 32'h0, 32'h0000_010C, 32'h0);
        chk("flush/T1 rd_en", {31'h0, dccm_rd_en}, 32'd1);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush/T3 ready", {31'h0, ready_o}, 32'd1);
        chk("flush/T3 wb_en", {31'h0, wb_en_o}, 32'd0);
        @(negedge clk);
        chk_quiet("flush/T4");
        issue(opc(3'd2, OpSt), 5'd0, 32'h0, 32'h0000_0500, 32'h1357_9BDF);
        chk("flush/SW wr_en", {31'h0, dccm_wr_en}, 32'd1);
        chk("flush/SW wr_addr", dccm_wr_addr, 32'h0000_0500);
        chk("flush/SW wr_data", dccm_wr_data, 32'h1357_9BDF);

        // Flush in idle drops the op presented with it.
        flush_i = 1'b1;
        issue(opc(3'd0, OpAlu), 5'd3, 32'h0000_0042, 32'h0, 32'h0);
        flush_i = 1'b0;
        chk_quiet("flushidle");
        chk("flushidle/ready", {31'h0, ready_o}, 32'd1);

        // New op accepted in the load writeback cycle.
        mem_word = 32'h0F0F_1234;
        issue(opc(3'd2, OpLd), 5'd4, 32'h0, 32'h0000_0120, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b/ld wb_en", {31'h0, wb_en_o}, 32'd1);
        chk("b2b/ld wb_data", wb_data_o, 32'h0F0F_1234);
        issue(opc(3'd0, OpAlu), 5'd6, 32'h0000_0077, 32'h0, 32'h0);
        chk("b2b/alu wb_en", {31'h0, wb_en_o}, 32'd1);
        chk("b2b/alu wb_rd", {27'h0, wb_rd_o}, 32'd6);
        chk("b2b/alu wb_data", wb_data_o, 32'h0000_0077);

        // Reset while in read-modify-write capture.
        mem_word = 32'h1122_3344;
        issue(opc(3'd1, OpSt), 5'd0, 32'h0, 32'h0000_0202, 32'hAAAA_BEEF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid/pulses", {28'h0, wb_en_o, dccm_wr_en, mem_err_o, dccm_rd_en}, 32'h0);
        chk("rstmid/rd_addr", dccm_rd_addr, 32'h0);
        chk("rstmid/wr_addr", dccm_wr_addr, 32'h0);
        chk("rstmid/wr_data", dccm_wr_data, 32'h0);
        chk("rstmid/wb_data", wb_data_o, 32'h0);
        chk("rstmid/wb_rd", {27'h0, wb_rd_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid/after%0d", i), {30'h0, dccm_wr_en, ready_o}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
